// File: rtl/bpd_pkg.sv
// rtl/bpd_pkg.sv - shared widths, state encoding and update record for the predictor update scheduler
package bpd_pkg;

  // Table index widths: global history / global PHT, local history / BHT
  localparam int BPD_GHR_W = 12;
  localparam int BPD_LHR_W = 10;

  // PC slice kept per update: PC[13:2] feeds the global hash, PC[11:2] the BHT
  localparam int PC_IDX_LO  = 2;
  localparam int PC_IDX_HI  = 13;
  localparam int PC_IDX_W   = PC_IDX_HI - PC_IDX_LO + 1;
  localparam int PC_BIDX_W  = 10;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic [PC_IDX_W-1:0]  pc_idx;
    logic [BPD_GHR_W-1:0] bhr;
    logic [BPD_LHR_W-1:0] bht;
    logic                 brdir;
    logic                 chwe;
    logic                 chbrdir;
  } upd_rec_t;

endpackage

// File: rtl/bpd_updq.sv
// rtl/bpd_updq.sv - small synchronous FIFO holding pending predictor updates
module bpd_updq #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];

  // A push into a full queue is legal only when the head leaves in the same cycle
  assign do_push = push & (!full | pop);
  assign do_pop  = pop & !empty;

  // Storage array; contents are only meaningful between the pointers
  always_ff @(posedge clock) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; flush discards everything pending
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/bpd_upd_sched.sv
// rtl/bpd_upd_sched.sv - init sweep and fetch-aware write scheduling for the tournament predictor tables
module bpd_upd_sched
  import bpd_pkg::*;
#(
  parameter int QDEPTH       = 4,
  parameter int STARVE_MAX   = 8,
  parameter int INIT_ENTRIES = 4096,
  parameter int GHR_W        = BPD_GHR_W,
  parameter int LHR_W        = BPD_LHR_W,
  localparam int QCW         = $clog2(QDEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             init_req_i,
  input  logic             upd_vld_i,
  output logic             upd_rdy_o,
  input  logic [63:0]      upd_pc_i,
  input  logic [GHR_W-1:0] upd_bhr_i,
  input  logic [LHR_W-1:0] upd_bht_i,
  input  logic             upd_brdir_i,
  input  logic             upd_chwe_i,
  input  logic             upd_chbrdir_i,
  input  logic             fetch_rd_req_i,
  output logic             stall_fetch_o,
  output logic             tbl_we_o,
  output logic             tbl_init_o,
  output logic [GHR_W-1:0] tbl_gidx_o,
  output logic [LHR_W-1:0] tbl_bidx_o,
  output logic [LHR_W-1:0] tbl_lidx_o,
  output logic             tbl_brdir_o,
  output logic             tbl_chwe_o,
  output logic             tbl_chdir_o,
  output logic             busy_o,
  output logic [QCW-1:0]   q_cnt_o
);

  // Sweep counter must be wide enough to drive the widest table index
  localparam int ICW = ($clog2(INIT_ENTRIES) > GHR_W) ? $clog2(INIT_ENTRIES) : GHR_W;
  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_ENTRIES - 1);
  localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

  sched_state_t   state, state_d;
  logic [ICW-1:0] init_cnt, init_cnt_d;
  logic [SCW-1:0] starve_cnt, starve_cnt_d;

  upd_rec_t       in_rec;
  upd_rec_t       head;
  logic           q_push;
  logic           q_pop;
  logic           q_full;
  logic           q_empty;
  logic           force_issue;
  logic           issue;
  logic           pc_unused;

  // Only PC[13:2] is ever used for indexing
  assign pc_unused = ^{upd_pc_i[63:PC_IDX_HI+1], upd_pc_i[PC_IDX_LO-1:0]};

  assign in_rec.pc_idx  = upd_pc_i[PC_IDX_HI:PC_IDX_LO];
  assign in_rec.bhr     = BPD_GHR_W'(upd_bhr_i);
  assign in_rec.bht     = BPD_LHR_W'(upd_bht_i);
  assign in_rec.brdir   = upd_brdir_i;
  assign in_rec.chwe    = upd_chwe_i;
  assign in_rec.chbrdir = upd_chbrdir_i;

  assign q_push = upd_vld_i & upd_rdy_o;

  bpd_updq #(
    .DEPTH (QDEPTH),
    .W     ($bits(upd_rec_t))
  ) u_updq (
    .clock     (clock),
    .reset     (reset),
    .flush     (init_req_i),
    .push      (q_push),
    .push_data (in_rec),
    .pop       (q_pop),
    .pop_data  (head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_cnt_o)
  );

  assign force_issue = (starve_cnt == STARVE_LIM);
  assign busy_o      = (state == S_INIT) | !q_empty;

  // State, sweep position and starvation counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_INIT;
      init_cnt   <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_d;
      init_cnt   <= init_cnt_d;
      starve_cnt <= starve_cnt_d;
    end
  end

  // Next state plus table write strobes; every strobe is held low while reset is asserted
  always_comb begin
    state_d       = state;
    init_cnt_d    = init_cnt;
    starve_cnt_d  = starve_cnt;
    issue         = 1'b0;
    q_pop         = 1'b0;
    upd_rdy_o     = 1'b0;
    stall_fetch_o = 1'b0;
    tbl_we_o      = 1'b0;
    tbl_init_o    = 1'b0;
    tbl_chwe_o    = 1'b0;
    tbl_gidx_o    = GHR_W'(head.pc_idx) ^ GHR_W'(head.bhr);
    tbl_bidx_o    = LHR_W'(head.pc_idx[PC_BIDX_W-1:0]);
    tbl_lidx_o    = LHR_W'(head.bht);
    tbl_brdir_o   = head.brdir;
    tbl_chdir_o   = head.brdir ^ head.chbrdir;

    if (!reset) begin
      case (state)
        S_INIT: begin
          tbl_we_o      = 1'b1;
          tbl_init_o    = 1'b1;
          tbl_chwe_o    = 1'b1;
          stall_fetch_o = 1'b1;
          tbl_gidx_o    = init_cnt[GHR_W-1:0];
          tbl_bidx_o    = init_cnt[LHR_W-1:0];
          tbl_lidx_o    = init_cnt[LHR_W-1:0];
          tbl_brdir_o   = 1'b0;
          tbl_chdir_o   = 1'b0;
          starve_cnt_d  = '0;
          init_cnt_d    = init_cnt + 1'b1;
          if (init_cnt == INIT_LAST) begin
            state_d    = S_RUN;
            init_cnt_d = '0;
          end
        end
        S_RUN: begin
          upd_rdy_o = !q_full;
          if (q_empty) begin
            starve_cnt_d = '0;
          end else begin
            stall_fetch_o = force_issue;
            issue         = !fetch_rd_req_i | force_issue;
            if (issue) begin
              q_pop        = 1'b1;
              tbl_we_o     = 1'b1;
              tbl_chwe_o   = head.chwe;
              starve_cnt_d = '0;
            end else if (starve_cnt != STARVE_LIM) begin
              starve_cnt_d = starve_cnt + 1'b1;
            end
          end
        end
        default: state_d = S_INIT;
      endcase

      if (init_req_i) begin
        state_d      = S_INIT;
        init_cnt_d   = '0;
        starve_cnt_d = '0;
      end
    end
  end

endmodule

// File: tb/tb_bpd_upd_sched.sv
// tb/tb_bpd_upd_sched.sv - directed self-checking bench for the predictor update scheduler
module tb_bpd_upd_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic        init_req_i;
  logic        upd_vld_i;
  logic        upd_rdy_o;
  logic [63:0] upd_pc_i;
  logic [11:0] upd_bhr_i;
  logic [9:0]  upd_bht_i;
  logic        upd_brdir_i;
  logic        upd_chwe_i;
  logic        upd_chbrdir_i;
  logic        fetch_rd_req_i;
  logic        stall_fetch_o;
  logic        tbl_we_o;
  logic        tbl_init_o;
  logic [11:0] tbl_gidx_o;
  logic [9:0]  tbl_bidx_o;
  logic [9:0]  tbl_lidx_o;
  logic        tbl_brdir_o;
  logic        tbl_chwe_o;
  logic        tbl_chdir_o;
  logic        busy_o;
  logic [2:0]  q_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  bpd_upd_sched dut (
    .clock          (clock),
    .reset          (reset),
    .init_req_i     (init_req_i),
    .upd_vld_i      (upd_vld_i),
    .upd_rdy_o      (upd_rdy_o),
    .upd_pc_i       (upd_pc_i),
    .upd_bhr_i      (upd_bhr_i),
    .upd_bht_i      (upd_bht_i),
    .upd_brdir_i    (upd_brdir_i),
    .upd_chwe_i     (upd_chwe_i),
    .upd_chbrdir_i  (upd_chbrdir_i),
    .fetch_rd_req_i (fetch_rd_req_i),
    .stall_fetch_o  (stall_fetch_o),
    .tbl_we_o       (tbl_we_o),
    .tbl_init_o     (tbl_init_o),
    .tbl_gidx_o     (tbl_gidx_o),
    .tbl_bidx_o     (tbl_bidx_o),
    .tbl_lidx_o     (tbl_lidx_o),
    .tbl_brdir_o    (tbl_brdir_o),
    .tbl_chwe_o     (tbl_chwe_o),
    .tbl_chdir_o    (tbl_chdir_o),
    .busy_o         (busy_o),
    .q_cnt_o        (q_cnt_o)
  );

  typedef struct {
    logic [63:0] pc;
    logic [11:0] bhr;
    logic [9:0]  bht;
    logic        brdir;
    logic        chwe;
    logic        chbrdir;
    logic [11:0] e_gidx;
    logic [9:0]  e_bidx;
    logic [9:0]  e_lidx;
    logic        e_chdir;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_upd(input logic [63:0] pc, input logic [11:0] bhr, input logic [9:0] bht,
                           input logic brdir, input logic chwe, input logic chbrdir);
    upd_vld_i     = 1'b1;
    upd_pc_i      = pc;
    upd_bhr_i     = bhr;
    upd_bht_i     = bht;
    upd_brdir_i   = brdir;
    upd_chwe_i    = chwe;
    upd_chbrdir_i = chbrdir;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int found;

    vt[0] = '{64'h1004, 12'h0F0, 10'h02A, 1'b1, 1'b1, 1'b0, 12'h4F1, 10'h001, 10'h02A, 1'b1};
    vt[1] = '{64'h3FFC, 12'hFFF, 10'h3FF, 1'b0, 1'b0, 1'b1, 12'h000, 10'h3FF, 10'h3FF, 1'b1};
    vt[2] = '{64'hFFFF_FFFF_FFFF_C000, 12'hABC, 10'h155, 1'b1, 1'b1, 1'b1, 12'hABC, 10'h000, 10'h155, 1'b0};
    vt[3] = '{64'h2468, 12'h123, 10'h000, 1'b0, 1'b1, 1'b1, 12'h839, 10'h11A, 10'h000, 1'b1};
    vt[4] = '{64'h5555_5555_5555_5557, 12'h555, 10'h2AA, 1'b1, 1'b0, 1'b0, 12'h000, 10'h155, 10'h2AA, 1'b1};

    reset          = 1'b1;
    init_req_i     = 1'b0;
    fetch_rd_req_i = 1'b0;
    upd_vld_i      = 1'b0;
    upd_pc_i       = '0;
    upd_bhr_i      = '0;
    upd_bht_i      = '0;
    upd_brdir_i    = 1'b0;
    upd_chwe_i     = 1'b0;
    upd_chbrdir_i  = 1'b0;

    // Reset: every strobe low
    for (int r = 0; r < 3; r++) begin
      @(negedge clock);
      chk("reset_strobes", {tbl_we_o, tbl_init_o, tbl_chwe_o, upd_rdy_o, stall_fetch_o}, 5'b00000);
      tick();
    end
    reset = 1'b0;

    // Initialisation sweep: 4096 init writes with ascending indices
    bad = 0;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clock);
      if ({tbl_we_o, tbl_init_o, stall_fetch_o, tbl_chwe_o, upd_rdy_o} !== 5'b11110 ||
          tbl_gidx_o !== 12'(i) || tbl_bidx_o !== 10'(i) || tbl_lidx_o !== 10'(i)) bad++;
      tick();
    end
    chk("init_sweep_bad_cycles", bad, 0);
    @(negedge clock);
    chk("run_rdy", upd_rdy_o, 1'b1);
    chk("run_busy", busy_o, 1'b0);
    chk("run_we", tbl_we_o, 1'b0);
    chk("run_stall", stall_fetch_o, 1'b0);
    tick();

    // Table of single updates: accepted one cycle, written the next
    for (int v = 0; v < 5; v++) begin
      drive_upd(vt[v].pc, vt[v].bhr, vt[v].bht, vt[v].brdir, vt[v].chwe, vt[v].chbrdir);
      @(negedge clock);
      chk("vec_no_bypass_we", tbl_we_o, 1'b0);
      chk("vec_rdy", upd_rdy_o, 1'b1);
      tick();
      upd_vld_i = 1'b0;
      @(negedge clock);
      chk("vec_we", tbl_we_o, 1'b1);
      chk("vec_init", tbl_init_o, 1'b0);
      chk("vec_gidx", tbl_gidx_o, vt[v].e_gidx);
      chk("vec_bidx", tbl_bidx_o, vt[v].e_bidx);
      chk("vec_lidx", tbl_lidx_o, vt[v].e_lidx);
      chk("vec_brdir", tbl_brdir_o, vt[v].brdir);
      chk("vec_chwe", tbl_chwe_o, vt[v].chwe);
      chk("vec_chdir", tbl_chdir_o, vt[v].e_chdir);
      tick();
    end
    @(negedge clock);
    chk("vec_drained_cnt", q_cnt_o, 3'd0);
    chk("vec_drained_busy", busy_o, 1'b0);
    tick();

    // Starvation: 8 blocked cycles, forced write on the 9th
    fetch_rd_req_i = 1'b1;
    drive_upd(vt[0].pc, vt[0].bhr, vt[0].bht, vt[0].brdir, vt[0].chwe, vt[0].chbrdir);
    @(negedge clock);
    tick();
    upd_vld_i = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (tbl_we_o !== 1'b0 || stall_fetch_o !== 1'b0) bad++;
      tick();
    end
    chk("starve_blocked_cycles", bad, 0);
    @(negedge clock);
    chk("starve_force_stall", stall_fetch_o, 1'b1);
    chk("starve_force_we", tbl_we_o, 1'b1);
    chk("starve_force_gidx", tbl_gidx_o, 12'h4F1);
    tick();
    @(negedge clock);
    chk("starve_after_stall", stall_fetch_o, 1'b0);
    chk("starve_after_we", tbl_we_o, 1'b0);
    chk("starve_after_cnt", dut.starve_cnt, 0);
    chk("starve_after_qcnt", q_cnt_o, 3'd0);
    tick();

    // Full queue: four accepted, fifth refused, forced issue frees a slot, FIFO order
    for (int j = 0; j < 4; j++) begin
      drive_upd(64'h100 * (j + 1), 12'h000, 10'(j), 1'b1, 1'b1, 1'b0);
      @(negedge clock);
      chk("full_push_rdy", upd_rdy_o, 1'b1);
      tick();
    end
    drive_upd(64'h500, 12'h000, 10'h004, 1'b1, 1'b1, 1'b0);
    @(negedge clock);
    chk("full_rdy", upd_rdy_o, 1'b0);
    chk("full_cnt", q_cnt_o, 3'd4);
    found = 0;
    for (int w = 0; w < 20 && found == 0; w++) begin
      @(negedge clock);
      if (stall_fetch_o === 1'b1) begin
        found = 1;
        chk("full_force_we", tbl_we_o, 1'b1);
        chk("full_force_gidx", tbl_gidx_o, 12'h040);
        chk("full_force_rdy", upd_rdy_o, 1'b0);
      end
      tick();
    end
    chk("full_force_seen", found, 1);
    upd_vld_i = 1'b0;
    @(negedge clock);
    chk("full_after_cnt", q_cnt_o, 3'd3);
    chk("full_after_rdy", upd_rdy_o, 1'b1);
    tick();
    fetch_rd_req_i = 1'b0;
    for (int j = 1; j < 4; j++) begin
      @(negedge clock);
      chk("order_we", tbl_we_o, 1'b1);
      chk("order_gidx", tbl_gidx_o, 12'h040 * (j + 1));
      tick();
    end
    @(negedge clock);
    chk("order_done_we", tbl_we_o, 1'b0);
    chk("order_done_cnt", q_cnt_o, 3'd0);
    tick();

    // init_req flushes the queue; a second request restarts the sweep at 0
    fetch_rd_req_i = 1'b1;
    for (int j = 0; j < 3; j++) begin
      drive_upd(64'h600 + 64'h100 * j, 12'h000, 10'h000, 1'b1, 1'b1, 1'b0);
      @(negedge clock);
      tick();
    end
    upd_vld_i  = 1'b0;
    init_req_i = 1'b1;
    @(negedge clock);
    chk("flush_pre_cnt", q_cnt_o, 3'd3);
    tick();
    init_req_i = 1'b0;
    @(negedge clock);
    chk("flush_cnt", q_cnt_o, 3'd0);
    chk("flush_init", tbl_init_o, 1'b1);
    chk("flush_gidx", tbl_gidx_o, 12'd0);
    chk("flush_busy", busy_o, 1'b1);
    tick();
    bad = 0;
    for (int i = 1; i < 100; i++) begin
      @(negedge clock);
      if (tbl_init_o !== 1'b1 || tbl_gidx_o !== 12'(i)) bad++;
      tick();
    end
    chk("resweep_first_part", bad, 0);
    init_req_i = 1'b1;
    @(negedge clock);
    chk("restart_cycle_gidx", tbl_gidx_o, 12'd100);
    tick();
    init_req_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clock);
      if (tbl_we_o !== 1'b1 || tbl_init_o !== 1'b1 || tbl_gidx_o !== 12'(i)) bad++;
      tick();
    end
    chk("restart_sweep_bad_cycles", bad, 0);
    fetch_rd_req_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (tbl_we_o !== 1'b0 || busy_o !== 1'b0 || q_cnt_o !== 3'd0) bad++;
      tick();
    end
    chk("no_stale_writes", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
